uart_rx_param: RTL
==================

# uart_rx_param

Parametrised UART receiver for the serial link, and the next generation of the fixed 8N1 receiver. It adds the following to that receiver:
- configurable data width, parity mode and stop-bit count;
- a 2-flop input synchroniser;
- 3-sample majority voting with false-start rejection;
- per-frame parity and framing error flags.

It sits between the external RX pin and the byte-level consumer, such as a FIFO or command decoder.

## Interface
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); must be >= 4, otherwise elaboration error
- DATA_BITS, 8, data bits per frame, 5..9, sent LSB first
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_rx_serial  in  1  asynchronous serial input, idle high
- o_rx_dv  out  1  one-cycle pulse, frame complete
- o_rx_byte  out  DATA_BITS  received data, held until next o_rx_dv
- o_parity_err  out  1  parity mismatch for the frame just flagged; valid with o_rx_dv, held until the next o_rx_dv
- o_frame_err  out  1  any stop bit sampled 0; same validity and hold as o_parity_err
- o_rx_busy  out  1  high in every state except IDLE

## Operation
- Synchroniser: i_rx_serial passes through 2 flops reset to 1, then an edge register `prev` reset to 0.
- Start detection: in IDLE, start only on `prev`=1 and synced=0. A line held low out of reset is ignored until it has been seen high.
- States:
  - IDLE -> START on falling edge; bit counter cleared to 0.
  - START -> DATA if the start-bit vote is 0; otherwise back to IDLE (false start, no o_rx_dv).
  - DATA: DATA_BITS bits, shifted LSB first. -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: one bit; mismatch sets the parity error. -> STOP.
  - STOP: STOP_BITS bits; any 0 vote sets the framing error. After the vote of the last stop bit -> IDLE and o_rx_dv pulses.
- Bit timing:
  - Per-bit counter `cnt` runs 0..CLKS_PER_BIT-1 and advances to the next bit at CLKS_PER_BIT-1.
  - Samples are taken at H-1, H and H+1, where H = CLKS_PER_BIT/2 (integer divide).
  - Vote = majority of the 3 samples, resolved at cnt = H+1.
- Parity check: odd = XOR(data, parity bit) must be 1; even = XOR(data, parity bit) must be 0.
- Early return: the receiver returns to IDLE half a bit early, at the mid-point of the last stop bit. This allows back-to-back frames with zero idle gap.
- Erroneous frames still deliver o_rx_byte and o_rx_dv; the flags qualify the data.
- A break (line held low) yields data 0 with o_frame_err=1. The receiver then waits for the line to go high before re-arming.
- Reset mid-frame: all state is discarded immediately; no o_rx_dv is produced for the partial frame.

## Timing
- Reset values:
  - o_rx_dv = 0, o_rx_byte = 0, o_parity_err = 0, o_frame_err = 0, o_rx_busy = 0
  - state = IDLE; synchroniser flops = 1; `prev` = 0
- The synchroniser delays i_rx_serial by 2 cycles.
- Cycle numbering: T0 is the cycle in which IDLE sees the synced falling edge; `cnt` = 0 in the first START cycle (T0+1).
- Let K = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS - 1, the index of the last stop bit.
- Latency: o_rx_dv is high in cycle T0 + K·CLKS_PER_BIT + H + 2. o_rx_byte and both error flags update in that same cycle.
- o_rx_dv is high for exactly 1 cycle. Minimum spacing between pulses is one full frame.
- o_rx_busy rises at T0+1 and falls in the o_rx_dv cycle.
- A new falling edge seen in the o_rx_dv cycle's IDLE is accepted; there is no dead time.

## Structure
- Shared package uart_pkg:
  - PARITY_NONE/PARITY_ODD/PARITY_EVEN constants
  - state encoding (IDLE, START, DATA, PARITY, STOP)
  - CLKS_PER_BIT default for 50 MHz/115200
- One sub-module, uart_rx_sync: 2-flop synchroniser plus the `prev` register. Outputs are the synced level and the falling-edge strobe. It is reusable by future receivers.
- Everything else stays in uart_rx_param: FSM, counters, majority vote, shift register, error logic.

## Test plan
- 8N1, CLKS_PER_BIT=16, send 0xAB from a matching transmitter -> one o_rx_dv with 0xAB and both flags 0, at exactly T0 + 9·16 + 10.
- 8E1, send 0x3F with the parity bit forced to 1 -> o_rx_byte = 0x3F, o_parity_err = 1, o_frame_err = 0. Next frame, 0x3F with correct parity (0) -> o_parity_err clears.
- 7O2, send 0x55 with the second stop bit driven 0 -> o_frame_err = 1, o_rx_byte = 0x55. Then hold the line low for 20 bits -> exactly one frame with data 0 and o_frame_err = 1, followed by no further o_rx_dv until the line returns high.
- CLKS_PER_BIT=16, 4-cycle low glitch on an idle line -> no o_rx_dv; o_rx_busy pulses, then IDLE. A single-cycle low spike inside a data bit at H -> the majority vote keeps the correct bit value.
- 8N1 back-to-back, 0x00 then 0xFF with zero idle gap -> two o_rx_dv pulses, 0x00 then 0xFF, no errors.
- Assert i_rst_n low mid-DATA of 0xC3, release, then send 0x5A -> all outputs at reset values during reset, no o_rx_dv for 0xC3, next o_rx_dv is 0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver family: parity modes, FSM
// state encoding, default bit timing and the 3-sample majority vote.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // 50 MHz system clock at 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial line, followed by an
// edge register. The edge register resets to 0 so that a line which is
// low coming out of reset is not mistaken for a start edge straight away.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_fall
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  // Synchroniser chain and previous-level register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= i_async;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign o_level = s2_q;
  assign o_fall  = prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop
// bits, majority-voted mid-bit sampling, false-start rejection and
// per-frame parity/framing flags. Returns to IDLE at the vote of the last
// stop bit so that back-to-back frames need no idle gap.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_serial,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_rx_busy
);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
      $error("uart_rx_param: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
      $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
      $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;

  // The vote register is written on the edge that enters cnt = H+1, so the
  // three samples are the line levels seen while cnt = H-2, H-1 and H.
  localparam logic [CW-1:0] CNT_S0   = CW'(H - 2);
  localparam logic [CW-1:0] CNT_S1   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_VOTE = CW'(H);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          IS_ODD    = (PARITY == PARITY_ODD);

  logic                 rx_level;
  logic                 rx_fall;
  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_q;
  logic [1:0]           smp_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_acc_q;
  logic                 ferr_acc_q;
  logic                 rx_dv_q;
  logic [DATA_BITS-1:0] rx_byte_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 vote;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_rx_serial),
    .o_level (rx_level),
    .o_fall  (rx_fall)
  );

  assign vote = maj3(smp_q[0], smp_q[1], rx_level);

  // Frame FSM: bit timing, sampling, shifting and error accumulation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      smp_q      <= 2'b11;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      rx_dv_q    <= 1'b0;
      rx_byte_q  <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_dv_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        cnt_q <= '0;
        bit_q <= '0;
        if (rx_fall) begin
          state_q    <= ST_START;
          perr_acc_q <= 1'b0;
          ferr_acc_q <= 1'b0;
        end
      end else begin
        if (cnt_q == CNT_S0) smp_q[0] <= rx_level;
        if (cnt_q == CNT_S1) smp_q[1] <= rx_level;
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

        if (cnt_q == CNT_VOTE) begin
          unique case (state_q)
            ST_START:  if (vote) state_q <= ST_IDLE;
            ST_DATA:   shift_q <= {vote, shift_q[DATA_BITS-1:1]};
            ST_PARITY: perr_acc_q <= IS_ODD ? ~(^shift_q ^ vote) : (^shift_q ^ vote);
            ST_STOP: begin
              if (bit_q == LAST_STOP) begin
                state_q   <= ST_IDLE;
                rx_dv_q   <= 1'b1;
                rx_byte_q <= shift_q;
                perr_q    <= perr_acc_q;
                ferr_q    <= ferr_acc_q | ~vote;
              end else begin
                ferr_acc_q <= ferr_acc_q | ~vote;
              end
            end
            default: ;
          endcase
        end

        if (cnt_q == CNT_LAST) begin
          unique case (state_q)
            ST_START: begin
              state_q <= ST_DATA;
              bit_q   <= '0;
            end
            ST_DATA: begin
              if (bit_q == LAST_DATA) begin
                bit_q   <= '0;
                state_q <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                bit_q <= bit_q + 4'd1;
              end
            end
            ST_PARITY: begin
              state_q <= ST_STOP;
              bit_q   <= '0;
            end
            ST_STOP: bit_q <= bit_q + 4'd1;
            default: ;
          endcase
        end
      end
    end
  end

  assign o_rx_dv      = rx_dv_q;
  assign o_rx_byte    = rx_byte_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_rx_busy    = (state_q != ST_IDLE);

endmodule
